riscv_v_reduct_accum: RTL and testbench

- Downstream of the bitwise AND/OR/XOR byte-vector units in the vector ALU.
- Registers their per-beat result before writeback.
- For reduction ops spanning several datapath beats (LMUL>1), it folds each beat's partial reduction into a running accumulator and emits one final element.
- Non-reduction beats pass through as a 1-deep pipeline register with valid/ready handshake.

---
 rtl/riscv_v_pkg.sv | 30 +++
 rtl/riscv_v_reduct_accum_combine.sv | 36 +++
 rtl/riscv_v_reduct_accum.sv | 140 ++++++++++++++
 tb/tb_riscv_v_reduct_accum.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_v_pkg.sv
// Shared vector-ALU types for the reduction accumulator.
// Holds op/osize encodings, FSM states, beat limit and osize decode.
package riscv_v_pkg;

    localparam int RISCV_V_NUM_BYTES_DATA = 16;
    localparam int REDUCT_MAX_BEATS       = 8;

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2
    } reduct_op_e;

    // One-hot element size: bit0=8b, bit1=16b, bit2=32b, bit3=64b
    typedef logic [3:0] osize_t;

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } reduct_state_e;

    // Element size in bytes; the widest set bit wins if not one-hot
    function automatic int osize_to_bytes(input osize_t osize);
        if (osize[3])      return 8;
        else if (osize[2]) return 4;
        else if (osize[1]) return 2;
        else               return 1;
    endfunction

endpackage

// File: rtl/riscv_v_reduct_accum_combine.sv
// Combinational fold of one beat's partial into the running accumulator.
// Ports: acc, partial, op, osize in; combined out (bytes >= E forced to 0).
module riscv_v_reduct_accum_combine
    import riscv_v_pkg::*;
#(
    parameter int DATA_BYTES = RISCV_V_NUM_BYTES_DATA,
    parameter int BYTE_WIDTH = 8
) (
    input  logic [DATA_BYTES*BYTE_WIDTH-1:0] acc,
    input  logic [DATA_BYTES*BYTE_WIDTH-1:0] partial,
    input  logic [1:0]                       op,
    input  osize_t                           osize,
    output logic [DATA_BYTES*BYTE_WIDTH-1:0] combined
);

    logic [DATA_BYTES*BYTE_WIDTH-1:0] raw;
    int nbytes;

    always_comb begin
        case (op)
            OP_AND:  raw = acc & partial;
            OP_XOR:  raw = acc ^ partial;
            default: raw = acc | partial;  // reserved op 3 behaves as OR
        endcase
    end

    always_comb begin
        nbytes   = osize_to_bytes(osize);
        combined = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i < nbytes)
                combined[i*BYTE_WIDTH +: BYTE_WIDTH] = raw[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

endmodule

// File: rtl/riscv_v_reduct_accum.sv
// Result register / multi-beat reduction accumulator after the bitwise units.
// Ports: in_* beat with valid/ready, out_* beat with valid/ready, sticky out_overflow.
module riscv_v_reduct_accum
    import riscv_v_pkg::*;
#(
    parameter int DATA_BYTES = RISCV_V_NUM_BYTES_DATA,
    parameter int BYTE_WIDTH = 8,
    parameter int MAX_BEATS  = REDUCT_MAX_BEATS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_is_reduct,
    input  logic                             in_first,
    input  logic                             in_last,
    input  logic [1:0]                       in_op,
    input  logic [3:0]                       in_osize,
    input  logic [DATA_BYTES*BYTE_WIDTH-1:0] in_data,
    input  logic [DATA_BYTES-1:0]            in_byte_valid,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_BYTES*BYTE_WIDTH-1:0] out_data,
    output logic [DATA_BYTES-1:0]            out_byte_valid,
    output logic                             out_overflow
);

    localparam int W  = DATA_BYTES * BYTE_WIDTH;
    localparam int CW = $clog2(MAX_BEATS + 1);

    reduct_state_e           state_q, state_d;
    logic [W-1:0]            acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d, cnt_inc;
    logic [W-1:0]            partial, combined, out_data_d;
    logic [DATA_BYTES-1:0]   lane_en, out_bv_d;
    logic                    accept, start, emit, ovf_set;
    int                      nbytes;

    // Output slot frees up in the same cycle it drains
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    // In IDLE every reduct beat opens a new reduction
    assign start    = (state_q == S_IDLE) | in_first;
    assign cnt_inc  = (cnt_q == CW'(MAX_BEATS)) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        nbytes  = osize_to_bytes(in_osize);
        lane_en = '0;
        partial = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            lane_en[i] = (i < nbytes);
            if (lane_en[i] && in_byte_valid[i])
                partial[i*BYTE_WIDTH +: BYTE_WIDTH] = in_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    riscv_v_reduct_accum_combine #(
        .DATA_BYTES (DATA_BYTES),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_combine (
        .acc      (acc_q),
        .partial  (partial),
        .op       (in_op),
        .osize    (in_osize),
        .combined (combined)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state: every accepted reduct beat lands by its last flag
    always_comb begin
        state_d = state_q;
        if (accept && in_is_reduct)
            state_d = in_last ? S_IDLE : S_ACCUM;
    end

    // Datapath / output decisions
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        emit       = 1'b0;
        ovf_set    = 1'b0;
        out_data_d = out_data;
        out_bv_d   = out_byte_valid;
        if (accept) begin
            if (!in_is_reduct) begin
                emit       = 1'b1;
                out_data_d = in_data;
                out_bv_d   = in_byte_valid;
            end else if (start && in_last) begin
                emit       = 1'b1;
                out_data_d = partial;
                out_bv_d   = lane_en;
                acc_d      = '0;
                cnt_d      = '0;
            end else if (start) begin
                acc_d = partial;
                cnt_d = CW'(1);
            end else if (in_last) begin
                emit       = 1'b1;
                out_data_d = combined;
                out_bv_d   = lane_en;
                acc_d      = '0;
                cnt_d      = '0;
            end else begin
                acc_d   = combined;
                cnt_d   = cnt_inc;
                ovf_set = (cnt_inc == CW'(MAX_BEATS));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q          <= '0;
            cnt_q          <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_byte_valid <= '0;
            out_overflow   <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            if (emit) begin
                out_valid      <= 1'b1;
                out_data       <= out_data_d;
                out_byte_valid <= out_bv_d;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (ovf_set)
                out_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_v_reduct_accum.sv
// Self-checking bench for riscv_v_reduct_accum: directed cases plus
// randomized reductions against a byte-level fold model.
module tb_riscv_v_reduct_accum;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         in_is_reduct = 1'b0;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic [1:0]   in_op = 2'd0;
    logic [3:0]   in_osize = 4'd1;
    logic [127:0] in_data = '0;
    logic [15:0]  in_byte_valid = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic [15:0]  out_byte_valid;
    logic         out_overflow;

    int total = 0;
    int bad   = 0;
    logic [127:0] q[$];

    riscv_v_reduct_accum dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_is_reduct   (in_is_reduct),
        .in_first       (in_first),
        .in_last        (in_last),
        .in_op          (in_op),
        .in_osize       (in_osize),
        .in_data        (in_data),
        .in_byte_valid  (in_byte_valid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_byte_valid (out_byte_valid),
        .out_overflow   (out_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic drive(input logic r, input logic f, input logic l,
                         input logic [1:0] op, input logic [3:0] os,
                         input logic [127:0] d, input logic [15:0] bv);
        int n = 0;
        in_is_reduct  = r;
        in_first      = f;
        in_last       = l;
        in_op         = op;
        in_osize      = os;
        in_data       = d;
        in_byte_valid = bv;
        in_valid      = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_wait", 128'(n < 20), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    function automatic int ebytes(input logic [3:0] os);
        case (os)
            4'b0010: return 2;
            4'b0100: return 4;
            4'b1000: return 8;
            default: return 1;
        endcase
    endfunction

    function automatic logic [15:0] emask(input int e);
        logic [15:0] m = '0;
        for (int b = 0; b < e; b++) m[b] = 1'b1;
        return m;
    endfunction

    // Element-wise reduction of all queued beats, keeping the low e bytes
    function automatic logic [127:0] fold(input int op, input int e);
        logic [127:0] r = q[0];
        for (int i = 1; i < q.size(); i++) begin
            if (op == 0)      r = r & q[i];
            else if (op == 2) r = r ^ q[i];
            else              r = r | q[i];
        end
        for (int b = e; b < 16; b++) r[b*8 +: 8] = 8'h00;
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] pt, d, up;
        logic [31:0]  words [4];
        logic [15:0]  bv;
        logic [3:0]   os;
        int           n, op;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_out_bv", 128'(out_byte_valid), 128'(0));
        chk("rst_overflow", 128'(out_overflow), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Pass-through
        pt = 128'h0F0E0D0C0B0A09080706050403020100;
        drive(0, 0, 0, 2'd0, 4'b0001, pt, 16'hFFFF);
        chk("pt_valid", 128'(out_valid), 128'(1));
        chk("pt_data", out_data, pt);
        chk("pt_bv", 128'(out_byte_valid), 128'(16'hFFFF));
        chk("pt_in_ready", 128'(in_ready), 128'(1));

        // XOR, 4 beats, 32-bit
        words = '{32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888};
        for (int i = 0; i < 4; i++) begin
            up = rnd128();
            drive(1, i == 0, i == 3, 2'd2, 4'b0100, {up[127:32], words[i]}, 16'hFFFF);
            if (i < 3) chk("xor_no_out", 128'(out_valid), 128'(0));
        end
        chk("xor_valid", 128'(out_valid), 128'(1));
        chk("xor_data", out_data, 128'hFFFFFFFF);
        chk("xor_bv", 128'(out_byte_valid), 128'(16'h000F));

        // AND, 2 beats, 8-bit; then single OR beat
        up = rnd128();
        drive(1, 1, 0, 2'd0, 4'b0001, {up[127:8], 8'hF0}, 16'hFFFF);
        chk("and_no_out", 128'(out_valid), 128'(0));
        up = rnd128();
        drive(1, 0, 1, 2'd0, 4'b0001, {up[127:8], 8'h3C}, 16'hFFFF);
        chk("and_data", out_data, 128'h30);
        chk("and_bv", 128'(out_byte_valid), 128'(16'h0001));
        up = rnd128();
        drive(1, 1, 1, 2'd1, 4'b0001, {up[127:8], 8'hA5}, 16'hFFFF);
        chk("or1_valid", 128'(out_valid), 128'(1));
        chk("or1_data", out_data, 128'hA5);

        // Backpressure
        @(posedge clk); #1;
        out_ready = 1'b0;
        pt = rnd128();
        drive(0, 0, 0, 2'd0, 4'b0001, pt, 16'hA5A5);
        chk("bp_pending", 128'(out_valid), 128'(1));
        in_is_reduct = 1'b1; in_first = 1'b1; in_last = 1'b0;
        in_op = 2'd2; in_osize = 4'b0001;
        in_data = 128'h5A; in_byte_valid = 16'hFFFF;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_hold_data", out_data, pt);
            chk("bp_hold_valid", 128'(out_valid), 128'(1));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_drained", 128'(out_valid), 128'(0));
        drive(1, 0, 1, 2'd2, 4'b0001, 128'h0F, 16'hFFFF);
        chk("bp_red_data", out_data, 128'h55);

        // Randomized reductions with interleaved pass-through beats
        for (int t = 0; t < 30; t++) begin
            n  = $urandom_range(1, 8);
            op = $urandom_range(0, 3);
            os = 4'b0001 << $urandom_range(0, 3);
            q.delete();
            for (int i = 0; i < n; i++) begin
                if (i > 0 && $urandom_range(0, 2) == 0) begin
                    pt = rnd128();
                    bv = 16'($urandom);
                    drive(0, 0, 0, 2'($urandom), 4'($urandom), pt, bv);
                    chk("rnd_pt_data", out_data, pt);
                    chk("rnd_pt_bv", 128'(out_byte_valid), 128'(bv));
                end
                d = rnd128();
                q.push_back(d);
                drive(1, i == 0, i == n - 1, 2'(op), os, d, 16'hFFFF);
                if (i < n - 1) chk("rnd_no_out", 128'(out_valid), 128'(0));
            end
            chk("rnd_valid", 128'(out_valid), 128'(1));
            chk("rnd_data", out_data, fold(op, ebytes(os)));
            chk("rnd_bv", 128'(out_byte_valid), 128'(emask(ebytes(os))));
        end
        chk("rnd_no_ovf", 128'(out_overflow), 128'(0));

        // Restart in ACCUM
        drive(1, 1, 0, 2'd1, 4'b0001, 128'h11, 16'hFFFF);
        drive(1, 1, 0, 2'd1, 4'b0001, 128'h0F, 16'hFFFF);
        drive(1, 0, 1, 2'd1, 4'b0001, 128'hF0, 16'hFFFF);
        chk("restart_or", out_data, 128'hFF);
        drive(1, 1, 0, 2'd0, 4'b0001, 128'h00, 16'hFFFF);
        drive(1, 1, 0, 2'd0, 4'b0001, 128'hFF, 16'hFFFF);
        drive(1, 0, 1, 2'd0, 4'b0001, 128'h0F, 16'hFFFF);
        chk("restart_and", out_data, 128'h0F);

        // Overflow: 9 non-last beats, then close
        q.delete();
        for (int i = 0; i < 9; i++) begin
            d = 128'(1) << i;
            q.push_back(d);
            drive(1, i == 0, 0, 2'd1, 4'b0010, d, 16'hFFFF);
            if (i == 6) chk("ovf_before", 128'(out_overflow), 128'(0));
            if (i >= 7) chk("ovf_set", 128'(out_overflow), 128'(1));
        end
        d = 128'h8000;
        q.push_back(d);
        drive(1, 0, 1, 2'd1, 4'b0010, d, 16'hFFFF);
        chk("ovf_final", out_data, fold(1, 2));
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_sticky", 128'(out_overflow), 128'(1));

        // Reset mid-reduction
        drive(1, 1, 0, 2'd2, 4'b0100, 128'hDEADBEEF, 16'hFFFF);
        drive(1, 0, 0, 2'd2, 4'b0100, 128'hCAFEF00D, 16'hFFFF);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_data", out_data, 128'(0));
        chk("mid_rst_bv", 128'(out_byte_valid), 128'(0));
        chk("mid_rst_ovf", 128'(out_overflow), 128'(0));
        drive(1, 0, 1, 2'd2, 4'b0100, 128'h12345678, 16'hFFFF);
        chk("post_rst_valid", 128'(out_valid), 128'(1));
        chk("post_rst_data", out_data, 128'h12345678);
        chk("post_rst_bv", 128'(out_byte_valid), 128'(16'h000F));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
